// File: rtl/fb_soc_pkg.sv
// Shared definitions for the SoC's lightweight Avalon-MM PIO slaves.
// Holds the register word addresses of the input PIO and the encodings
// that choose which debounced edge direction is captured.
package fb_soc_pkg;

  // Register word addresses (word 1 is reserved and reads as zero).
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  // Edge capture selection.
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit of the PIO: a two-flop synchronizer followed by a
// debounce counter and the accepted (stable) value.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   in_i      asynchronous external pin
//   stable_o  debounced value, changes only after the synchronized input
//             has differed from it for DEBOUNCE_CYCLES consecutive cycles
module pio_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts whenever the input agrees with the stable value, so
  // any excursion shorter than DEBOUNCE_CYCLES is discarded.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= RESET_VALUE;
      sync2_q  <= RESET_VALUE;
      stable_q <= RESET_VALUE;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/button_input_pio.sv
// Avalon-MM slave input PIO for push-buttons / game controls.
// Each pin is synchronized and debounced, qualifying edges of the debounced
// value are latched into a CPU-clearable capture register, and a level
// interrupt is raised for captured bits enabled in the mask register.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        register word select (0 data, 1 reserved, 2 irq_mask,
//                  3 edge_capture)
//   chipselect     slave select; write_n active-low write strobe
//   writedata      32-bit write data
//   in_port        asynchronous external inputs
//   readdata       zero-wait combinational read data, zero-extended
//   irq            active-high level interrupt
// Bus handshake: no wait states; a write takes effect on the clk edge where
// chipselect is high and write_n low, and readdata is valid in the same
// cycle address is presented. Reads have no side effects.
module button_input_pio
  import fb_soc_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               EDGE_TYPE       = EDGE_RISING,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic             wr_en;
  logic             unused_writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (IN_RESET_VALUE[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .stable_o(stable[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_pulse = '0;
    if (EDGE_TYPE == EDGE_FALLING) begin
      edge_pulse = ~stable & stable_d_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      edge_pulse = stable ^ stable_d_q;
    end else begin
      edge_pulse = stable & ~stable_d_q;
    end
  end

  // A new edge is OR-ed in after the W1C clear, so it survives a clear of
  // the same bit in the same cycle.
  always_comb begin
    irq_mask_d     = irq_mask_q;
    edge_capture_d = edge_capture_q;
    if (wr_en && address == ADDR_IRQ_MASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGE_CAP) begin
      edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
    end
    edge_capture_d = edge_capture_d | edge_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_q     <= IN_RESET_VALUE;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      stable_d_q     <= stable;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[WIDTH-1:0] = stable;
      ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_capture_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

  // Upper write-data bits have no register behind them.
  assign unused_writedata = ^writedata;

endmodule

// File: tb/tb_button_input_pio.sv
module tb_button_input_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: rising edge, reset value 0
  button_input_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IN_RESET_VALUE(4'h0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  // DUT B: falling edge, active-low buttons
  button_input_pio #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IN_RESET_VALUE(4'hF)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input bit use_b, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = use_b ? readdata_b : readdata_a;
    chipselect = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = 4'h0;
    in_b       = 4'hF;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    bus_read(2'd0, 0, rd); check("rst_data", rd, 32'h0);
    bus_read(2'd2, 0, rd); check("rst_mask", rd, 32'h0);
    bus_read(2'd3, 0, rd); check("rst_cap", rd, 32'h0);
    check("rst_irq", {31'b0, irq_a}, 32'h0);
    bus_read(2'd0, 1, rd); check("rst_b_data", rd, 32'hF);
    bus_read(2'd3, 1, rd); check("rst_b_cap", rd, 32'h0);

    // Reserved word
    bus_write(2'd1, 32'hF);
    bus_read(2'd1, 0, rd); check("reserved", rd, 32'h0);
    // Data register is read-only
    bus_write(2'd0, 32'hF);
    bus_read(2'd0, 0, rd); check("data_ro", rd, 32'h0);

    // Clean rising edge on bit 0: stable 6 cycles after the change
    in_a = 4'h1;
    repeat (5) tick();
    bus_read(2'd0, 0, rd); check("lat5_data", rd, 32'h0);
    tick();
    bus_read(2'd0, 0, rd); check("lat6_data", rd, 32'h1);
    bus_read(2'd3, 0, rd); check("lat6_cap", rd, 32'h0);
    tick();
    bus_read(2'd3, 0, rd); check("lat7_cap", rd, 32'h1);
    check("irq_masked", {31'b0, irq_a}, 32'h0);

    // Glitch of 3 cycles on bit 2: rejected
    in_a = 4'h5;
    repeat (3) tick();
    in_a = 4'h1;
    repeat (10) tick();
    bus_read(2'd0, 0, rd); check("glitch3_data", rd, 32'h1);
    bus_read(2'd3, 0, rd); check("glitch3_cap", rd, 32'h1);

    // Pulse of exactly 4 cycles on bit 2: accepted
    in_a = 4'h5;
    repeat (4) tick();
    in_a = 4'h1;
    repeat (12) tick();
    bus_read(2'd3, 0, rd); check("pulse4_cap", rd, 32'h5);
    bus_read(2'd0, 0, rd); check("pulse4_data", rd, 32'h1);

    // Interrupt mask and W1C
    bus_write(2'd2, 32'h1);
    check("irq_on", {31'b0, irq_a}, 32'h1);
    bus_read(2'd2, 0, rd); check("mask_rb", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_off", {31'b0, irq_a}, 32'h0);
    bus_read(2'd3, 0, rd); check("w1c_bit0", rd, 32'h4);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, 0, rd); check("w1c_bit2", rd, 32'h0);

    // chipselect low: write ignored
    address    = 2'd2;
    writedata  = 32'hF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick();
    write_n    = 1'b1;
    bus_read(2'd2, 0, rd); check("cs_low", rd, 32'h1);

    // W1C of bit 3 on the same edge its rising edge is captured
    in_a = 4'h9;
    repeat (6) tick();
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, 0, rd); check("set_wins", rd, 32'h8);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, 0, rd); check("w1c_bit3", rd, 32'h0);

    // Falling-edge instance: bit 1 pressed (driven low)
    in_b = 4'hD;
    repeat (8) tick();
    bus_read(2'd0, 1, rd); check("b_data", rd, 32'hD);
    bus_read(2'd3, 1, rd); check("b_fall_cap", rd, 32'h2);
    // Release: rising edge must not be captured
    in_b = 4'hF;
    repeat (8) tick();
    bus_read(2'd0, 1, rd); check("b_rel_data", rd, 32'hF);
    bus_read(2'd3, 1, rd); check("b_rise_ignored", rd, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
